// File: rtl/dpram_be_clr_if.sv
// Bus bundle for dpram_be_clr: read/write request signals toward the RAM,
// read data, read-valid and clear-busy flag back to the requester.
interface dpram_be_clr_if #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 4
);
  logic                  RCSN;
  logic [ADDR_WIDTH-1:0] RA;
  logic                  WCSN;
  logic                  WEN;
  logic [WIDTH/8-1:0]    BEN;
  logic [ADDR_WIDTH-1:0] WA;
  logic [WIDTH-1:0]      D;
  logic [WIDTH-1:0]      Q;
  logic                  QV;
  logic                  BUSY;

  modport master (
    output RCSN, RA, WCSN, WEN, BEN, WA, D,
    input  Q, QV, BUSY
  );

  modport slave (
    input  RCSN, RA, WCSN, WEN, BEN, WA, D,
    output Q, QV, BUSY
  );
endinterface

// File: rtl/dpram_be_clr.sv
// Single-clock 1R/1W RAM with active-low byte-lane write enables, selectable
// same-address collision policy, optional output register and post-reset clear.
module dpram_be_clr #(
  parameter int WORDS      = 16,
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int COLL_MODE  = 1,
  parameter int OUT_REG    = 0,
  parameter int CLR_EN     = 1
) (
  input  logic           CLK,
  input  logic           RSTN,
  dpram_be_clr_if.slave  bus
);

  localparam int LANES = WIDTH / 8;

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  busy;

  logic [WIDTH-1:0]      mem_q [WORDS];

  logic                  ra_ok, wa_ok;
  logic                  rd_req, wr_req, coll;
  logic [ADDR_WIDTH-1:0] wr_addr, rd_idx;
  logic [WIDTH-1:0]      wr_data;
  logic [LANES-1:0]      wr_lane;
  logic [WIDTH-1:0]      q_p0;

  logic [WIDTH-1:0]      q_p1_q, q_p1_d;
  logic                  vld_p1_q, vld_p1_d;

  // Lanes written in the same edge as a read of the same word take their
  // value from the collision policy; unwritten lanes always keep old data.
  function automatic logic [WIDTH-1:0] resolve_collision(
    input logic [WIDTH-1:0] old_data,
    input logic [WIDTH-1:0] new_data,
    input logic [LANES-1:0] lane_hit
  );
    logic [WIDTH-1:0] r;
    r = old_data;
    for (int i = 0; i < LANES; i++) begin
      if (lane_hit[i]) begin
        if (COLL_MODE == 0)
          r[8*i +: 8] = 'x;
        else if (COLL_MODE == 2)
          r[8*i +: 8] = new_data[8*i +: 8];
      end
    end
    return r;
  endfunction

  assign busy     = (state_q == ST_CLEAR);
  assign bus.BUSY = busy;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (32'(cnt_q) == WORDS - 1) begin
        state_d = ST_READY;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= (CLR_EN != 0) ? ST_CLEAR : ST_READY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    ra_ok   = 32'(bus.RA) < WORDS;
    wa_ok   = 32'(bus.WA) < WORDS;
    wr_req  = !busy && !bus.WCSN && !bus.WEN && wa_ok;
    rd_req  = !busy && !bus.RCSN;
    coll    = rd_req && wr_req && (bus.RA == bus.WA);
    wr_addr = busy ? cnt_q : bus.WA;
    wr_data = busy ? '0 : bus.D;
    rd_idx  = ra_ok ? bus.RA : '0;
    for (int i = 0; i < LANES; i++)
      wr_lane[i] = busy || (wr_req && !bus.BEN[i]);
  end

  // The clear sequencer shares the write port; the array itself is not reset.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < LANES; i++)
      if (wr_lane[i])
        mem_q[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
  end

  // p0: array lookup with collision resolution
  always_comb begin
    q_p0 = '0;
    if (ra_ok)
      q_p0 = resolve_collision(mem_q[rd_idx], bus.D, coll ? ~bus.BEN : '0);
    q_p1_d   = rd_req ? q_p0 : q_p1_q;
    vld_p1_d = rd_req;
  end

  // p1: first read register, Q holds when no read is issued
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      q_p1_q   <= '0;
      vld_p1_q <= 1'b0;
    end else begin
      q_p1_q   <= q_p1_d;
      vld_p1_q <= vld_p1_d;
    end
  end

  // p2: optional output register
  if (OUT_REG != 0) begin : g_out_reg
    logic [WIDTH-1:0] q_p2_q, q_p2_d;
    logic             vld_p2_q, vld_p2_d;

    always_comb begin
      q_p2_d   = vld_p1_q ? q_p1_q : q_p2_q;
      vld_p2_d = vld_p1_q;
    end

    always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
        q_p2_q   <= '0;
        vld_p2_q <= 1'b0;
      end else begin
        q_p2_q   <= q_p2_d;
        vld_p2_q <= vld_p2_d;
      end
    end

    assign bus.Q  = q_p2_q;
    assign bus.QV = vld_p2_q;
  end else begin : g_no_out_reg
    assign bus.Q  = q_p1_q;
    assign bus.QV = vld_p1_q;
  end

endmodule

// File: tb/tb_dpram_be_clr.sv
// Bench for dpram_be_clr: two instances (16 words/read-first/latency 1 and
// 12 words/write-through/latency 2) driven identically, checked against a model.
module tb_dpram_be_clr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic        rcsn, wcsn, wen;
  logic [3:0]  ra, wa;
  logic [1:0]  ben;
  logic [15:0] d;

  dpram_be_clr_if #(.WIDTH(16), .ADDR_WIDTH(4)) if0 ();
  dpram_be_clr_if #(.WIDTH(16), .ADDR_WIDTH(4)) if1 ();

  assign if0.RCSN = rcsn;  assign if1.RCSN = rcsn;
  assign if0.RA   = ra;    assign if1.RA   = ra;
  assign if0.WCSN = wcsn;  assign if1.WCSN = wcsn;
  assign if0.WEN  = wen;   assign if1.WEN  = wen;
  assign if0.BEN  = ben;   assign if1.BEN  = ben;
  assign if0.WA   = wa;    assign if1.WA   = wa;
  assign if0.D    = d;     assign if1.D    = d;

  dpram_be_clr #(.WORDS(16), .WIDTH(16), .ADDR_WIDTH(4), .COLL_MODE(1),
                 .OUT_REG(0), .CLR_EN(1)) u0 (.CLK(clk), .RSTN(rstn), .bus(if0));
  dpram_be_clr #(.WORDS(12), .WIDTH(16), .ADDR_WIDTH(4), .COLL_MODE(2),
                 .OUT_REG(1), .CLR_EN(1)) u1 (.CLK(clk), .RSTN(rstn), .bus(if1));

  int tests = 0;
  int fails = 0;

  // Reference model: per instance, array contents, remaining clear cycles,
  // a short history of issued reads and the expected held output.
  int          words_m [2] = '{16, 12};
  int          mode_m  [2] = '{1, 2};
  int          lat_m   [2] = '{1, 2};
  logic [15:0] mmem    [2][16];
  int          busy_left [2];
  logic [15:0] hq [2][2];
  logic        hv [2][2];
  logic [15:0] eq [2];
  logic        ev [2];

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      busy_left[k] = words_m[k];
      eq[k] = '0;
      ev[k] = 1'b0;
      for (int j = 0; j < 2; j++) begin
        hq[k][j] = '0;
        hv[k][j] = 1'b0;
      end
      for (int a = 0; a < 16; a++) mmem[k][a] = '0;
    end
  endfunction

  function automatic void model_edge(input int k);
    logic        rv;
    logic [15:0] rdat;
    logic        wr;
    int          w;
    w    = words_m[k];
    rv   = 1'b0;
    rdat = '0;
    if (rstn == 1'b0) return;
    if (busy_left[k] > 0) begin
      busy_left[k]--;
    end else begin
      wr = !wcsn && !wen && (int'(wa) < w);
      if (!rcsn) begin
        rv = 1'b1;
        if (int'(ra) < w) begin
          rdat = mmem[k][ra];
          for (int i = 0; i < 2; i++)
            if (wr && wa == ra && !ben[i] && mode_m[k] == 2)
              rdat[8*i +: 8] = d[8*i +: 8];
        end
      end
      if (wr)
        for (int i = 0; i < 2; i++)
          if (!ben[i]) mmem[k][wa][8*i +: 8] = d[8*i +: 8];
    end
    hq[k][1] = hq[k][0];  hv[k][1] = hv[k][0];
    hq[k][0] = rdat;      hv[k][0] = rv;
    ev[k] = hv[k][lat_m[k]-1];
    if (ev[k]) eq[k] = hq[k][lat_m[k]-1];
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("q0",    32'(if0.Q),    32'(eq[0]));
    chk("qv0",   32'(if0.QV),   32'(ev[0]));
    chk("busy0", 32'(if0.BUSY), 32'(busy_left[0] > 0));
    chk("q1",    32'(if1.Q),    32'(eq[1]));
    chk("qv1",   32'(if1.QV),   32'(ev[1]));
    chk("busy1", 32'(if1.BUSY), 32'(busy_left[1] > 0));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle();
    rcsn = 1'b1; ra = '0; wcsn = 1'b1; wen = 1'b1; ben = 2'b11; wa = '0; d = '0;
  endtask

  typedef struct {
    logic        rcsn;
    logic [3:0]  ra;
    logic        wcsn;
    logic        wen;
    logic [1:0]  ben;
    logic [3:0]  wa;
    logic [15:0] d;
    logic [15:0] eq;
    logic        eqv;
  } vec_t;

  vec_t tbl [15];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, n1, run0, run1, max0, max1;

    tbl[0]  = '{1'b1, 4'd0,  1'b0, 1'b0, 2'b00, 4'd3,  16'hBEEF, 16'h0000, 1'b0};
    tbl[1]  = '{1'b0, 4'd3,  1'b1, 1'b1, 2'b11, 4'd0,  16'h0000, 16'hBEEF, 1'b1};
    tbl[2]  = '{1'b1, 4'd0,  1'b0, 1'b0, 2'b10, 4'd3,  16'h1234, 16'hBEEF, 1'b0};
    tbl[3]  = '{1'b0, 4'd3,  1'b1, 1'b1, 2'b11, 4'd0,  16'h0000, 16'hBE34, 1'b1};
    tbl[4]  = '{1'b1, 4'd0,  1'b0, 1'b0, 2'b00, 4'd5,  16'hAAAA, 16'hBE34, 1'b0};
    tbl[5]  = '{1'b0, 4'd5,  1'b0, 1'b0, 2'b00, 4'd5,  16'h5555, 16'hAAAA, 1'b1};
    tbl[6]  = '{1'b0, 4'd5,  1'b1, 1'b1, 2'b11, 4'd0,  16'h0000, 16'h5555, 1'b1};
    tbl[7]  = '{1'b0, 4'd7,  1'b1, 1'b1, 2'b11, 4'd0,  16'h0000, 16'h0000, 1'b1};
    tbl[8]  = '{1'b0, 4'd5,  1'b0, 1'b0, 2'b01, 4'd5,  16'hFFFF, 16'h5555, 1'b1};
    tbl[9]  = '{1'b0, 4'd5,  1'b1, 1'b1, 2'b11, 4'd0,  16'h0000, 16'hFF55, 1'b1};
    tbl[10] = '{1'b0, 4'd5,  1'b0, 1'b1, 2'b00, 4'd5,  16'h0000, 16'hFF55, 1'b1};
    tbl[11] = '{1'b0, 4'd5,  1'b1, 1'b0, 2'b00, 4'd5,  16'h0000, 16'hFF55, 1'b1};
    tbl[12] = '{1'b0, 4'd5,  1'b1, 1'b1, 2'b11, 4'd0,  16'h0000, 16'hFF55, 1'b1};
    tbl[13] = '{1'b0, 4'd15, 1'b0, 1'b0, 2'b11, 4'd15, 16'h1111, 16'h0000, 1'b1};
    tbl[14] = '{1'b0, 4'd15, 1'b1, 1'b1, 2'b11, 4'd0,  16'h0000, 16'h0000, 1'b1};

    // Reset and post-reset clear
    idle();
    rstn = 1'b0;
    model_reset();
    @(negedge clk);
    check_all();
    step();
    rstn = 1'b1;
    n0 = 0; n1 = 0;
    for (int i = 0; i < 40 && (if0.BUSY || if1.BUSY); i++) begin
      n0 += int'(if0.BUSY);
      n1 += int'(if1.BUSY);
      step();
    end
    chk("busy_cycles0", 32'(n0), 32'd16);
    chk("busy_cycles1", 32'(n1), 32'd12);
    for (int a = 0; a < 16; a++) begin
      rcsn = 1'b0; ra = 4'(a);
      step();
      chk("clr_rd_q",  32'(if0.Q),  32'h0);
      chk("clr_rd_qv", 32'(if0.QV), 32'h1);
    end
    idle();
    step();

    // Directed vectors: writes, byte lanes, collisions, disabled writes
    for (int i = 0; i < 15; i++) begin
      rcsn = tbl[i].rcsn; ra = tbl[i].ra; wcsn = tbl[i].wcsn; wen = tbl[i].wen;
      ben = tbl[i].ben; wa = tbl[i].wa; d = tbl[i].d;
      step();
      chk("tbl_q",  32'(if0.Q),  32'(tbl[i].eq));
      chk("tbl_qv", 32'(if0.QV), 32'(tbl[i].eqv));
      if (i == 6) chk("coll_mode2", 32'(if1.Q), 32'h5555);
    end
    idle();
    step();

    // Out-of-range access on the 12-word instance
    wcsn = 1'b0; wen = 1'b0; ben = 2'b00; wa = 4'd13; d = 16'hAAAA;
    step();
    idle();
    rcsn = 1'b0; ra = 4'd13;
    step();
    idle();
    step();
    chk("oor_q1",  32'(if1.Q),  32'h0);
    chk("oor_qv1", 32'(if1.QV), 32'h1);
    step();

    // Back-to-back reads of 0..11
    run0 = 0; run1 = 0; max0 = 0; max1 = 0;
    for (int i = 0; i < 15; i++) begin
      if (i < 12) begin rcsn = 1'b0; ra = 4'(i); end
      else idle();
      step();
      run0 = if0.QV ? run0 + 1 : 0;
      run1 = if1.QV ? run1 + 1 : 0;
      if (run0 > max0) max0 = run0;
      if (run1 > max1) max1 = run1;
    end
    chk("qv_run0", 32'(max0), 32'd12);
    chk("qv_run1", 32'(max1), 32'd12);

    // Reset pulse during clear restarts it; writes while busy are lost
    rstn = 1'b0;
    model_reset();
    #1;
    check_all();
    step();
    rstn = 1'b1;
    for (int i = 0; i < 7; i++) step();
    rstn = 1'b0;
    model_reset();
    step();
    rstn = 1'b1;
    wcsn = 1'b0; wen = 1'b0; ben = 2'b00; wa = 4'd2; d = 16'h1234;
    n0 = 0; n1 = 0;
    for (int i = 0; i < 40 && (if0.BUSY || if1.BUSY); i++) begin
      n0 += int'(if0.BUSY);
      n1 += int'(if1.BUSY);
      if (!if0.BUSY) idle();
      step();
    end
    chk("rst_busy0", 32'(n0), 32'd16);
    chk("rst_busy1", 32'(n1), 32'd12);
    idle();
    rcsn = 1'b0; ra = 4'd2;
    step();
    chk("busy_wr_lost", 32'(if0.Q), 32'h0);
    idle();
    step();

    // Randomized traffic with frequent same-address collisions
    for (int i = 0; i < 1500; i++) begin
      rcsn = ($urandom % 4) == 0;
      ra   = 4'($urandom);
      wcsn = ($urandom % 3) == 0;
      wen  = ($urandom % 4) == 0;
      ben  = 2'($urandom);
      wa   = (($urandom % 3) == 0) ? ra : 4'($urandom);
      d    = 16'($urandom);
      step();
    end
    idle();
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
